// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbiter.
// Holds the line width and the arbiter state encoding.
package rv32i_types;

    typedef logic [31:0]  rv32i_word;
    typedef logic [255:0] llc_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates Icache and Dcache line requests onto one cacheline adaptor.
// Non-preemptive; round-robin or fixed Dcache priority on contention.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_pmem_read,
    input  logic         i_pmem_write,
    input  rv32i_word    i_pmem_address,
    input  llc_cacheline i_pmem_wdata,
    output llc_cacheline i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  rv32i_word    d_pmem_address,
    input  llc_cacheline d_pmem_wdata,
    output llc_cacheline d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output rv32i_word    pmem_address,
    output llc_cacheline pmem_wdata,
    input  llc_cacheline pmem_rdata,
    input  logic         pmem_resp
);

    arb_state_t state, state_n;
    logic       last_d, last_d_n;
    logic       i_req, d_req;
    logic       pick_i, pick_d;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    // last_d set means Dcache won the previous grant
    assign pick_i = (i_req && d_req) ? (RR_EN && last_d) : i_req;
    assign pick_d = (i_req | d_req) & ~pick_i;

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_n;
            last_d <= last_d_n;
        end
    end

    always_comb begin
        state_n  = state;
        last_d_n = last_d;
        case (state)
            IDLE: begin
                unique case (1'b1)
                    pick_i: begin
                        state_n  = SERVE_I;
                        last_d_n = 1'b0;
                    end
                    pick_d: begin
                        state_n  = SERVE_D;
                        last_d_n = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
            SERVE_I,
            SERVE_D: begin
                if (pmem_resp) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even mid-transaction
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    pmem_read    = i_pmem_read & ~i_pmem_write;
                    pmem_write   = i_pmem_write;
                    pmem_address = i_pmem_address;
                    pmem_wdata   = i_pmem_wdata;
                    i_pmem_resp  = pmem_resp;
                end
                SERVE_D: begin
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_write   = d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    d_pmem_resp  = pmem_resp;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: one round-robin and one fixed-priority
// instance driven by the same requester and memory stimulus.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, i_write, d_read, d_write;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] i_wdata, d_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    logic [255:0] r_i_rdata, r_d_rdata, f_i_rdata, f_d_rdata;
    logic         r_i_resp, r_d_resp, f_i_resp, f_d_resp;
    logic         r_read, r_write, f_read, f_write;
    logic [31:0]  r_addr, f_addr;
    logic [255:0] r_wdata, f_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] pat_a5;
    logic [255:0] pat_w;
    logic         exp_d;

    always #5 clk = ~clk;

    cache_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_read), .i_pmem_write(i_write),
        .i_pmem_address(i_addr), .i_pmem_wdata(i_wdata),
        .i_pmem_rdata(r_i_rdata), .i_pmem_resp(r_i_resp),
        .d_pmem_read(d_read), .d_pmem_write(d_write),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(r_d_rdata), .d_pmem_resp(r_d_resp),
        .pmem_read(r_read), .pmem_write(r_write),
        .pmem_address(r_addr), .pmem_wdata(r_wdata),
        .pmem_rdata(mem_rdata), .pmem_resp(mem_resp)
    );

    cache_arbiter #(.RR_EN(1'b0)) dut_fx (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_read), .i_pmem_write(i_write),
        .i_pmem_address(i_addr), .i_pmem_wdata(i_wdata),
        .i_pmem_rdata(f_i_rdata), .i_pmem_resp(f_i_resp),
        .d_pmem_read(d_read), .d_pmem_write(d_write),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(f_d_rdata), .d_pmem_resp(f_d_resp),
        .pmem_read(f_read), .pmem_write(f_write),
        .pmem_address(f_addr), .pmem_wdata(f_wdata),
        .pmem_rdata(mem_rdata), .pmem_resp(mem_resp)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change at posedge+2, checks at posedge+3
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic quiet_rr(input string tag);
        chk_b({tag, "_rd"}, r_read, 1'b0);
        chk_b({tag, "_wr"}, r_write, 1'b0);
        chk_a({tag, "_addr"}, r_addr, 32'h0);
        chk_v({tag, "_wdata"}, r_wdata, 256'h0);
        chk_b({tag, "_iresp"}, r_i_resp, 1'b0);
        chk_b({tag, "_dresp"}, r_d_resp, 1'b0);
    endtask

    initial begin
        pat_a5    = {32{8'hA5}};
        pat_w     = {8{32'hDEAD_0001}};
        rst       = 1'b1;
        i_read    = 1'b0;
        i_write   = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        i_addr    = 32'h0;
        d_addr    = 32'h0;
        i_wdata   = 256'h0;
        d_wdata   = 256'h0;
        mem_rdata = 256'h0;
        mem_resp  = 1'b0;

        // reset: outputs quiet, rdata still follows memory
        tick;
        tick;
        mem_rdata = pat_w;
        settle;
        quiet_rr("rst");
        chk_v("rst_irdata", r_i_rdata, pat_w);
        chk_v("rst_drdata", r_d_rdata, pat_w);
        rst = 1'b0;
        tick;

        // Icache read, response on cycle 5
        i_read = 1'b1;
        i_addr = 32'h0000_0060;
        settle;
        chk_b("ird_c0_rd", r_read, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick;
            settle;
            chk_b("ird_rd", r_read, 1'b1);
            chk_b("ird_wr", r_write, 1'b0);
            chk_a("ird_addr", r_addr, 32'h60);
            chk_b("ird_iresp", r_i_resp, 1'b0);
        end
        tick;
        mem_resp  = 1'b1;
        mem_rdata = pat_a5;
        settle;
        chk_b("ird_c5_rd", r_read, 1'b1);
        chk_b("ird_c5_iresp", r_i_resp, 1'b1);
        chk_b("ird_c5_dresp", r_d_resp, 1'b0);
        chk_v("ird_c5_rdata", r_i_rdata, pat_a5);
        tick;
        mem_resp = 1'b0;
        i_read   = 1'b0;
        settle;
        quiet_rr("ird_done");
        tick;
        settle;
        quiet_rr("ird_idle");

        // stale request held through the DONE cycle
        i_read = 1'b1;
        i_addr = 32'h0000_0080;
        tick;
        settle;
        chk_b("stale_serve_rd", r_read, 1'b1);
        tick;
        mem_resp = 1'b1;
        settle;
        chk_b("stale_iresp", r_i_resp, 1'b1);
        tick;
        mem_resp = 1'b0;
        settle;
        chk_b("stale_done_rd", r_read, 1'b0);
        chk_b("stale_done_iresp", r_i_resp, 1'b0);
        tick;
        i_read = 1'b0;
        settle;
        chk_b("stale_idle_rd", r_read, 1'b0);
        tick;
        settle;
        chk_b("stale_after_rd", r_read, 1'b0);

        // Dcache read+write together: write wins
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_0300;
        d_wdata = pat_w;
        tick;
        settle;
        chk_b("drw_wr", r_write, 1'b1);
        chk_b("drw_rd", r_read, 1'b0);
        chk_a("drw_addr", r_addr, 32'h300);
        chk_v("drw_wdata", r_wdata, pat_w);
        tick;
        mem_resp = 1'b1;
        settle;
        chk_b("drw_dresp", r_d_resp, 1'b1);
        chk_b("drw_iresp", r_i_resp, 1'b0);
        tick;
        mem_resp = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        settle;
        quiet_rr("drw_done");
        tick;

        // reset in the middle of an Icache read
        i_read = 1'b1;
        i_addr = 32'h0000_0400;
        tick;
        settle;
        chk_b("rstmid_serve_rd", r_read, 1'b1);
        tick;
        rst      = 1'b1;
        mem_resp = 1'b1;
        settle;
        quiet_rr("rstmid_held");
        tick;
        rst      = 1'b0;
        mem_resp = 1'b0;
        i_read   = 1'b0;
        settle;
        quiet_rr("rstmid_idle");
        tick;
        settle;
        quiet_rr("rstmid_after");

        // contention with both held: RR gives D,I,D; fixed gives D,D,D
        i_read  = 1'b1;
        i_addr  = 32'h0000_0100;
        d_write = 1'b1;
        d_addr  = 32'h0000_0200;
        settle;
        chk_b("cont_c0_rd", r_read, 1'b0);
        chk_b("cont_c0_wr", r_write, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_d = (k != 1);
            tick;
            settle;
            chk_b("rr_grant_wr", r_write, exp_d);
            chk_b("rr_grant_rd", r_read, !exp_d);
            chk_a("rr_grant_addr", r_addr, exp_d ? 32'h200 : 32'h100);
            chk_b("fx_grant_wr", f_write, 1'b1);
            chk_a("fx_grant_addr", f_addr, 32'h200);
            tick;
            mem_resp = 1'b1;
            settle;
            chk_b("rr_dresp", r_d_resp, exp_d);
            chk_b("rr_iresp", r_i_resp, !exp_d);
            chk_b("fx_dresp", f_d_resp, 1'b1);
            chk_b("fx_iresp", f_i_resp, 1'b0);
            tick;
            mem_resp = 1'b0;
            settle;
            chk_b("rr_done_rd", r_read, 1'b0);
            chk_b("rr_done_wr", r_write, 1'b0);
            chk_b("fx_done_wr", f_write, 1'b0);
            tick;
            settle;
            chk_b("rr_idle_wr", r_write, 1'b0);
            chk_b("fx_idle_rd", f_read, 1'b0);
        end
        i_read  = 1'b0;
        d_write = 1'b0;
        tick;
        tick;
        settle;
        quiet_rr("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 selects round-robin on contention; 0 selects fixed Dcache priority.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have i_pmem_read, i_pmem_write, inputs, 1 bit each: Icache line requests.
REQ-005 SHALL have i_pmem_address, input, 32 bits (rv32i_word): Icache line address.
REQ-006 SHALL have i_pmem_wdata, input, llc_cacheline (256 bits): Icache write line.
REQ-007 SHALL have i_pmem_rdata, output, llc_cacheline: read line to Icache.
REQ-008 SHALL have i_pmem_resp, output, 1 bit: Icache completion.
REQ-009 SHALL have d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata and d_pmem_resp, the Dcache set, with the same directions and widths as REQ-004..008.
REQ-010 SHALL have pmem_read and pmem_write, outputs, 1 bit each: downstream request to the cacheline adaptor.
REQ-011 SHALL have pmem_address, output, 32 bits: downstream address.
REQ-012 SHALL have pmem_wdata, output, llc_cacheline: downstream write line.
REQ-013 SHALL have pmem_rdata, input, llc_cacheline: downstream read line.
REQ-014 SHALL have pmem_resp, input, 1 bit: downstream completion, single-cycle pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, SERVE_I, SERVE_D and DONE.
REQ-016 In IDLE, a requester is pending when its read or write is high. With only Icache pending, next state SHALL be SERVE_I; with only Dcache pending, SERVE_D; with none pending, IDLE.
REQ-017 When both requesters are pending and RR_EN=1, the FSM SHALL grant the requester not granted last. The last-grant flag SHALL update on every grant.
REQ-018 When both requesters are pending and RR_EN=0, the FSM SHALL grant Dcache.
REQ-019 Grant latency: pmem_read/pmem_write SHALL first assert the cycle after the request is seen in IDLE; the arbiter never asserts them in IDLE or DONE.
REQ-020 In SERVE_x, the downstream outputs SHALL be driven from requester x: pmem_read = x_read & ~x_write, pmem_write = x_write, plus x's address and wdata. Write takes precedence if both read and write are high.
REQ-021 In SERVE_x, when pmem_resp=1, x_pmem_resp SHALL assert for exactly that cycle and the next state SHALL be DONE.
REQ-022 The non-granted requester's resp SHALL stay 0 throughout.
REQ-023 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata combinationally; only resp is steered.
REQ-024 DONE SHALL last exactly one cycle and then go to IDLE, so a requester still showing a stale request in its resp cycle is not re-granted.
REQ-025 A request dropped by its requester in SERVE_x before pmem_resp is illegal; the arbiter SHALL keep waiting for pmem_resp and is not required to recover.
REQ-026 pmem_address and pmem_wdata SHALL be 0 in IDLE and DONE.
REQ-027 The arbiter SHALL be non-preemptive: a new request from the other side while in SERVE_x SHALL be held off until IDLE.

Reset
REQ-028 When rst=1 at a clock edge, the state SHALL become IDLE from any state, including mid-SERVE.
REQ-029 When rst=1 at a clock edge, the last-grant flag SHALL become Icache, so the first RR contention grants Dcache.
REQ-030 During and after reset, all outputs SHALL be 0 (rdata outputs excepted, which follow pmem_rdata). A downstream transaction in flight at reset is abandoned.

Structure
REQ-031 The state enum arb_state_t and llc_cacheline SHALL live in rv32i_types; no other shared constants are needed.
REQ-032 The block SHALL be one module with no sub-modules; FSM next-state logic and output muxing are in the same file.

Verification
REQ-033 Icache read only, addr 0x0000_0060, pmem_resp on cycle 5 with pmem_rdata = 0xA5 repeated -> pmem_read high cycles 1..5, i_pmem_resp=1 on cycle 5 only, i_pmem_rdata matches, DONE on cycle 6.
REQ-034 Both request in the same cycle after reset with RR_EN=1 (I read 0x100, D write 0x200) -> D served first with pmem_write=1 and address 0x200, then after DONE/IDLE I served with address 0x100; d_pmem_resp precedes i_pmem_resp.
REQ-035 Contention repeated three times with RR_EN=1 -> grant order D, I, D; with RR_EN=0 -> D every time while D keeps requesting.
REQ-036 Dcache asserts read and write together, addr 0x300 -> pmem_write=1 and pmem_read=0.
REQ-037 rst asserted during SERVE_I before pmem_resp -> IDLE next cycle, pmem_read=0, i_pmem_resp never pulses.
REQ-038 Requester holds read one cycle after its resp -> no second downstream request is issued for it until after DONE.
